// File: rtl/crossing_stop_controller.sv
// Debounced zebra-crossing stop sequencer with confirm, minimum-hold, release hysteresis and frame watchdog.
// Define CROSSING_STATS_EN to add the saturating stop_events / fault_events counters.
module crossing_stop_controller #(
    parameter int CONFIRM_FRAMES  = 3,
    parameter int MIN_HOLD_FRAMES = 30,
    parameter int CLEAR_FRAMES    = 5,
    parameter int WHITE_MIN       = 2000,
    parameter int CNT_W           = 19,
    parameter int TIMEOUT_CYCLES  = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             detection_valid,
    input  logic             crossing_detected,
    input  logic [CNT_W-1:0] white_count,
    output logic             stop,
    output logic             stop_pulse,
    output logic             release_pulse,
    output logic             fault,
`ifdef CROSSING_STATS_EN
    output logic [15:0]      stop_events,
    output logic [7:0]       fault_events,
`endif
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMING    = 3'd1,
        S_STOP      = 3'd2,
        S_RELEASING = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam int HIT_W  = (CONFIRM_FRAMES  < 1) ? 1 : $clog2(CONFIRM_FRAMES + 1);
    localparam int HOLD_W = (MIN_HOLD_FRAMES < 1) ? 1 : $clog2(MIN_HOLD_FRAMES + 1);
    localparam int MISS_W = (CLEAR_FRAMES    < 1) ? 1 : $clog2(CLEAR_FRAMES + 1);
    localparam int WD_W   = (TIMEOUT_CYCLES  < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    localparam logic [HIT_W-1:0]  HIT_TARGET  = HIT_W'(CONFIRM_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(MIN_HOLD_FRAMES);
    localparam logic [MISS_W-1:0] MISS_TARGET = MISS_W'(CLEAR_FRAMES);
    localparam logic [WD_W-1:0]   WD_TERM     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WHITE_TH    = CNT_W'(WHITE_MIN);

    state_t              cur_state, nxt_state;
    logic [HIT_W-1:0]    hit_cnt, hit_nxt, hit_inc;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt, hold_inc;
    logic [MISS_W-1:0]   miss_cnt, miss_nxt, miss_inc;
    logic [WD_W-1:0]     wd_cnt, wd_nxt;
    logic                frame_event, hit, miss, stop_nxt;

    assign frame_event = detection_valid;
    assign hit         = frame_event && crossing_detected && (white_count >= WHITE_TH);
    assign miss        = frame_event && !hit;

    assign hit_inc  = hit_cnt + HIT_W'(1);
    assign miss_inc = miss_cnt + MISS_W'(1);
    assign hold_inc = (hold_cnt >= HOLD_TARGET) ? hold_cnt : hold_cnt + HOLD_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        nxt_state = cur_state;
        hit_nxt   = hit_cnt;
        hold_nxt  = hold_cnt;
        miss_nxt  = miss_cnt;

        if (!enable) begin
            nxt_state = S_IDLE;
            hit_nxt   = '0;
            hold_nxt  = '0;
            miss_nxt  = '0;
        end else if (frame_event) begin
            unique case (cur_state)
                S_IDLE: begin
                    if (hit) begin
                        if (CONFIRM_FRAMES <= 1) begin
                            nxt_state = S_STOP;
                            hold_nxt  = '0;
                            miss_nxt  = '0;
                        end else begin
                            nxt_state = S_ARMING;
                            hit_nxt   = HIT_W'(1);
                        end
                    end
                end
                S_ARMING: begin
                    if (!hit) begin
                        nxt_state = S_IDLE;
                        hit_nxt   = '0;
                    end else if (hit_inc >= HIT_TARGET) begin
                        nxt_state = S_STOP;
                        hit_nxt   = '0;
                        hold_nxt  = '0;
                        miss_nxt  = '0;
                    end else begin
                        hit_nxt = hit_inc;
                    end
                end
                S_STOP: begin
                    hold_nxt = hold_inc;
                    // Release hysteresis only starts once the minimum hold has elapsed.
                    if (miss && hold_inc >= HOLD_TARGET) begin
                        if (CLEAR_FRAMES <= 1) begin
                            nxt_state = S_IDLE;
                            hold_nxt  = '0;
                            miss_nxt  = '0;
                        end else begin
                            nxt_state = S_RELEASING;
                            miss_nxt  = MISS_W'(1);
                        end
                    end
                end
                S_RELEASING: begin
                    if (hit) begin
                        nxt_state = S_STOP;
                        miss_nxt  = '0;
                    end else if (miss_inc >= MISS_TARGET) begin
                        nxt_state = S_IDLE;
                        hold_nxt  = '0;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_inc;
                    end
                end
                default: begin
                    // Leaving FAULT: the waking event is not classified.
                    nxt_state = S_IDLE;
                    hit_nxt   = '0;
                    hold_nxt  = '0;
                    miss_nxt  = '0;
                end
            endcase
        end else if (wd_cnt == WD_TERM) begin
            nxt_state = S_FAULT;
            hit_nxt   = '0;
            hold_nxt  = '0;
            miss_nxt  = '0;
        end
    end

    always_comb begin
        wd_nxt = wd_cnt;
        if (!enable || frame_event) begin
            wd_nxt = '0;
        end else if (wd_cnt != WD_TERM) begin
            wd_nxt = wd_cnt + WD_W'(1);
        end
    end

    assign stop_nxt = (nxt_state == S_STOP) || (nxt_state == S_RELEASING) || (nxt_state == S_FAULT);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cur_state     <= S_IDLE;
            hit_cnt       <= '0;
            hold_cnt      <= '0;
            miss_cnt      <= '0;
            wd_cnt        <= '0;
            stop          <= 1'b0;
            stop_pulse    <= 1'b0;
            release_pulse <= 1'b0;
            fault         <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            hit_cnt       <= hit_nxt;
            hold_cnt      <= hold_nxt;
            miss_cnt      <= miss_nxt;
            wd_cnt        <= wd_nxt;
            stop          <= stop_nxt;
            stop_pulse    <= stop_nxt && !stop;
            release_pulse <= !stop_nxt && stop;
            fault         <= (nxt_state == S_FAULT);
        end
    end

`ifdef CROSSING_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_events  <= '0;
            fault_events <= '0;
        end else begin
            if (stop_nxt && !stop && stop_events != 16'hFFFF) begin
                stop_events <= stop_events + 16'd1;
            end
            if (nxt_state == S_FAULT && cur_state != S_FAULT && fault_events != 8'hFF) begin
                fault_events <= fault_events + 8'd1;
            end
        end
    end
`endif

    assign state = cur_state;

endmodule

// File: tb/tb_crossing_stop_controller.sv
// Scoreboard bench for crossing_stop_controller: stimulus queues expected outputs, a monitor compares them
// on the falling edge after each requested sample. Built with TIMEOUT_CYCLES=100 to exercise the watchdog.
module tb_crossing_stop_controller;

    localparam int CNT_W = 19;
    localparam int HIT   = 5000;

    logic             clk = 1'b0;
    logic             rst, enable, detection_valid, crossing_detected;
    logic [CNT_W-1:0] white_count;
    logic             stop, stop_pulse, release_pulse, fault;
    logic [2:0]       state;
`ifdef CROSSING_STATS_EN
    logic [15:0]      stop_events;
    logic [7:0]       fault_events;
`endif

    always #5 clk = ~clk;

    crossing_stop_controller #(
        .CONFIRM_FRAMES (3),
        .MIN_HOLD_FRAMES(30),
        .CLEAR_FRAMES   (5),
        .WHITE_MIN      (2000),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .detection_valid  (detection_valid),
        .crossing_detected(crossing_detected),
        .white_count      (white_count),
        .stop             (stop),
        .stop_pulse       (stop_pulse),
        .release_pulse    (release_pulse),
        .fault            (fault),
`ifdef CROSSING_STATS_EN
        .stop_events      (stop_events),
        .fault_events     (fault_events),
`endif
        .state            (state)
    );

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       stp;
        logic       sp;
        logic       rp;
        logic       flt;
    } exp_t;

    exp_t exp_q[$];
    logic sample_req = 1'b0;
    logic pending    = 1'b0;
    logic stim_done  = 1'b0;
    int   errors     = 0;
    int   checks     = 0;

    always @(posedge clk) pending <= sample_req;

    task automatic drive(input logic r, input logic en, input logic dv, input logic cd, input int wc);
        rst               = r;
        enable            = en;
        detection_valid   = dv;
        crossing_detected = cd;
        white_count       = CNT_W'(wc);
        sample_req        = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_chk(input logic r, input logic en, input logic dv, input logic cd, input int wc,
                             input string nm, input logic [2:0] st, input logic stp, input logic sp,
                             input logic rp, input logic flt);
        exp_t e;
        e.name = nm; e.st = st; e.stp = stp; e.sp = sp; e.rp = rp; e.flt = flt;
        exp_q.push_back(e);
        rst               = r;
        enable            = en;
        detection_valid   = dv;
        crossing_detected = cd;
        white_count       = CNT_W'(wc);
        sample_req        = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    // One frame: a checked verdict pulse followed by three quiet cycles.
    task automatic frame(input logic cd, input int wc, input string nm, input logic [2:0] st,
                         input logic stp, input logic sp, input logic rp, input logic flt);
        drive_chk(1'b0, 1'b1, 1'b1, cd, wc, nm, st, stp, sp, rp, flt);
        idle(3);
    endtask

    initial begin : monitor
        exp_t e;
        while (!stim_done) begin
            @(negedge clk);
            if (pending) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: sample requested with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if ({state, stop, stop_pulse, release_pulse, fault} !== {e.st, e.stp, e.sp, e.rp, e.flt}) begin
                        errors++;
                        $display("FAIL %s: got state=%0d stop=%b stop_pulse=%b release_pulse=%b fault=%b, expected state=%0d stop=%b stop_pulse=%b release_pulse=%b fault=%b",
                                 e.name, state, stop, stop_pulse, release_pulse, fault, e.st, e.stp, e.sp, e.rp, e.flt);
                    end
                end
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d expected entries never compared", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_timeout
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit exceeded");
    end

    initial begin : stimulus
        rst = 1'b1; enable = 1'b1; detection_valid = 1'b0; crossing_detected = 1'b0; white_count = '0;
        drive_chk(1'b1, 1'b1, 1'b0, 1'b0, 0, "reset", 3'd0, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);

        // White gate: crossing flagged but one pixel short of the threshold.
        for (int i = 0; i < 5; i++) frame(1'b1, 1999, "white_gate", 3'd0, 0, 0, 0, 0);

        // Confirm after three hits.
        frame(1'b1, HIT, "confirm_1", 3'd1, 0, 0, 0, 0);
        frame(1'b1, HIT, "confirm_2", 3'd1, 0, 0, 0, 0);
        frame(1'b1, HIT, "confirm_3", 3'd2, 1, 1, 0, 0);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, 0, "confirm_settle", 3'd2, 1, 0, 0, 0);

        // Minimum hold: misses 1..29 keep STOP, miss 30 starts releasing.
        for (int i = 1; i <= 29; i++) frame(1'b0, HIT, "hold_miss", 3'd2, 1, 0, 0, 0);
        frame(1'b0, HIT, "hold_done", 3'd3, 1, 0, 0, 0);
        frame(1'b1, 1999, "release_miss2", 3'd3, 1, 0, 0, 0);
        frame(1'b0, HIT, "release_miss3", 3'd3, 1, 0, 0, 0);
        frame(1'b1, HIT, "release_rehit", 3'd2, 1, 0, 0, 0);
        frame(1'b0, HIT, "rerelease_1", 3'd3, 1, 0, 0, 0);
        for (int i = 2; i <= 4; i++) frame(1'b0, HIT, "rerelease_n", 3'd3, 1, 0, 0, 0);
        frame(1'b0, HIT, "rerelease_5", 3'd0, 0, 0, 1, 0);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, 0, "release_settle", 3'd0, 0, 0, 0, 0);

        // Debounce: hit, hit, miss, hit.
        frame(1'b1, HIT, "debounce_hit1", 3'd1, 0, 0, 0, 0);
        frame(1'b1, HIT, "debounce_hit2", 3'd1, 0, 0, 0, 0);
        frame(1'b0, HIT, "debounce_miss", 3'd0, 0, 0, 0, 0);
        frame(1'b1, HIT, "debounce_hit3", 3'd1, 0, 0, 0, 0);
        frame(1'b0, HIT, "debounce_clear", 3'd0, 0, 0, 0, 0);

        // Watchdog: an event on the terminal count wins; a full 100 quiet cycles faults.
        drive_chk(1'b0, 1'b1, 1'b1, 1'b0, HIT, "wd_ref", 3'd0, 0, 0, 0, 0);
        idle(99);
        drive_chk(1'b0, 1'b1, 1'b1, 1'b0, HIT, "wd_terminal_event", 3'd0, 0, 0, 0, 0);
        idle(98);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, 0, "wd_pre_fault", 3'd0, 0, 0, 0, 0);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, 0, "wd_fault", 3'd4, 1, 1, 0, 1);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, 0, "wd_fault_hold", 3'd4, 1, 0, 0, 1);
        drive_chk(1'b0, 1'b1, 1'b1, 1'b1, HIT, "wd_exit", 3'd0, 0, 0, 1, 0);
        drive_chk(1'b0, 1'b1, 1'b0, 1'b0, 0, "wd_exit_settle", 3'd0, 0, 0, 0, 0);

        // Reset while stopped.
        frame(1'b1, HIT, "rst_seq_1", 3'd1, 0, 0, 0, 0);
        frame(1'b1, HIT, "rst_seq_2", 3'd1, 0, 0, 0, 0);
        frame(1'b1, HIT, "rst_seq_3", 3'd2, 1, 1, 0, 0);
        drive_chk(1'b1, 1'b1, 1'b0, 1'b0, 0, "rst_in_stop", 3'd0, 0, 0, 0, 0);
        idle(2);

        // Disable while releasing.
        frame(1'b1, HIT, "en_seq_1", 3'd1, 0, 0, 0, 0);
        frame(1'b1, HIT, "en_seq_2", 3'd1, 0, 0, 0, 0);
        frame(1'b1, HIT, "en_seq_3", 3'd2, 1, 1, 0, 0);
        for (int i = 1; i <= 29; i++) frame(1'b0, HIT, "en_hold", 3'd2, 1, 0, 0, 0);
        frame(1'b0, HIT, "en_releasing", 3'd3, 1, 0, 0, 0);
        drive_chk(1'b0, 1'b0, 1'b0, 1'b0, 0, "enable_off", 3'd0, 0, 0, 1, 0);
        drive_chk(1'b0, 1'b0, 1'b1, 1'b1, HIT, "enable_off_hold", 3'd0, 0, 0, 0, 0);

        idle(2);
        stim_done = 1'b1;
    end

endmodule
